// File: rtl/lda_line_scheduler_if.sv
// rtl/lda_line_scheduler_if.sv - command, LDA and status signals of lda_line_scheduler
interface lda_line_scheduler_if;
  logic        req0_valid;
  logic [36:0] req0_cmd;
  logic        req0_ready;
  logic        req1_valid;
  logic [36:0] req1_cmd;
  logic        req1_ready;
  logic        start;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [8:0]  x1;
  logic [7:0]  y1;
  logic [2:0]  colour;
  logic        done;
  logic        busy;
  logic        grant_id;
  logic [15:0] lines_done;
  logic        err_timeout;
  logic        err_clear;

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, done, err_clear,
    output req0_ready, req1_ready, start, x0, y0, x1, y1, colour,
           busy, grant_id, lines_done, err_timeout
  );

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, done, err_clear,
    input  req0_ready, req1_ready, start, x0, y0, x1, y1, colour,
           busy, grant_id, lines_done, err_timeout
  );
endinterface

// File: rtl/lda_line_scheduler.sv
// rtl/lda_line_scheduler.sv - round-robin LDA command scheduler with done watchdog
module lda_line_scheduler #(
  parameter int unsigned TIMEOUT = 200000
) (
  input logic                 clk,
  input logic                 reset_n,
  lda_line_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [19:0] WD_LAST = 20'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        grant_id_q, grant_id_d;
  logic        err_q, err_d;
  logic [8:0]  x0_q, x0_d, x1_q, x1_d;
  logic [7:0]  y0_q, y0_d, y1_q, y1_d;
  logic [2:0]  colour_q, colour_d;
  logic [15:0] lines_done_q, lines_done_d;
  logic [19:0] wd_q, wd_d;
  logic        idle, grant0, grant1;
  logic [36:0] cmd_sel;

  // rr names the requester that wins when both are valid
  assign idle    = (state_q == IDLE);
  assign grant0  = bus.req0_valid & (~bus.req1_valid | ~rr_q);
  assign grant1  = bus.req1_valid & (~bus.req0_valid | rr_q);
  assign cmd_sel = grant1 ? bus.req1_cmd : bus.req0_cmd;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_id_d   = grant_id_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    colour_d     = colour_q;
    lines_done_d = lines_done_q;
    wd_d         = wd_q;
    err_d        = bus.err_clear ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          x0_d       = cmd_sel[8:0];
          y0_d       = cmd_sel[16:9];
          x1_d       = cmd_sel[25:17];
          y1_d       = cmd_sel[33:26];
          colour_d   = cmd_sel[36:34];
          grant_id_d = grant1;
          rr_d       = ~grant1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_q + 20'd1;
        // done takes priority over a watchdog expiring in the same cycle
        if (bus.done) begin
          lines_done_d = lines_done_q + 16'd1;
          state_d      = IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      grant_id_q   <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      colour_q     <= '0;
      lines_done_q <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_id_q   <= grant_id_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      colour_q     <= colour_d;
      lines_done_q <= lines_done_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  assign bus.req0_ready  = idle & grant0;
  assign bus.req1_ready  = idle & grant1;
  assign bus.start       = (state_q == LAUNCH);
  assign bus.busy        = ~idle;
  assign bus.grant_id    = grant_id_q;
  assign bus.x0          = x0_q;
  assign bus.y0          = y0_q;
  assign bus.x1          = x1_q;
  assign bus.y1          = y1_q;
  assign bus.colour      = colour_q;
  assign bus.lines_done  = lines_done_q;
  assign bus.err_timeout = err_q;
endmodule
